// File: rtl/connect4_pkg.sv
// Shared Connect-Four types, cell codes, grid geometry and the grid bit-index helper.
package connect4_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int GRID_W     = 98;
  localparam int SEL_BASE   = 97;
  localparam int BOARD_BASE = 83;
  localparam int ROW_STRIDE = 14;

  typedef logic [1:0] cell_t;

  typedef enum logic [2:0] {
    ST_SELECT,
    ST_SCAN,
    ST_PLACE,
    ST_CHECK,
    ST_NEXT,
    ST_TERM
  } state_t;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_DR,
    DIR_UR
  } dir_t;

  // MSB of board cell (row, col) inside the display grid vector.
  function automatic int cell_idx(input int row, input int col);
    return BOARD_BASE - ROW_STRIDE * row - 2 * col;
  endfunction

endpackage

// File: rtl/connect4_if.sv
// Button levels in, board/selection grid and game status out, between the input stage and the game engine.
interface connect4_if;

  logic                              btn_left;
  logic                              btn_right;
  logic                              btn_drop;
  logic [connect4_pkg::GRID_W-1:0]   grid;
  logic [1:0]                        winner;
  logic                              term;
  logic                              busy;

  modport master (
    output btn_left, btn_right, btn_drop,
    input  grid, winner, term, busy
  );

  modport slave (
    input  btn_left, btn_right, btn_drop,
    output grid, winner, term, busy
  );

endinterface

// File: rtl/connect4_line_check.sv
// Flags WIN_LEN consecutive cells equal to the player code within a 7-cell line.
// Latency: combinational. Backpressure: none.
module connect4_line_check
  import connect4_pkg::*;
#(
  parameter int LINE_LEN = 7,
  parameter int WIN_LEN  = 4
) (
  input  logic [LINE_LEN-1:0][1:0] line,
  input  cell_t                    player,
  output logic                     match
);

  localparam int N_WIN = LINE_LEN - WIN_LEN + 1;

  logic [N_WIN-1:0] hit;

  for (genvar s = 0; s < N_WIN; s++) begin : g_win
    logic [WIN_LEN-1:0] eq;
    for (genvar k = 0; k < WIN_LEN; k++) begin : g_cell
      assign eq[k] = (line[s+k] == player);
    end
    assign hit[s] = &eq;
  end

  assign match = (|hit) && (player != CELL_EMPTY);

endmodule

// File: rtl/connect4_game.sv
// Connect-Four engine: cursor, gravity drop, 4-direction win check, draw detect. Macro CONNECT4_CURSOR_WRAP_EN wraps the cursor.
// Latency: drop-to-SELECT at most 12 cycles; all outputs registered, grid follows state by one cycle.
// Backpressure: none; button edges are ignored while busy (outside SELECT/TERM).
module connect4_game
  import connect4_pkg::*;
#(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  connect4_if.slave io
);

  localparam int         LINE_LEN  = 2 * WIN_LEN - 1;
  localparam int         HALF      = WIN_LEN - 1;
  localparam logic [5:0] MAX_MOVES = 6'(ROWS * COLS);

  state_t            state_q, state_nxt;
  cell_t             board_q [ROWS][COLS];
  logic [2:0]        cursor_q;
  logic [2:0]        row_q;
  dir_t              dir_q;
  cell_t             player_q;
  logic [5:0]        moves_q;
  logic              left_q, right_q, drop_q;
  logic [1:0]        winner_q;
  logic              term_q, busy_q;
  logic [GRID_W-1:0] grid_q, grid_nxt;

  logic left_edge, right_edge, drop_edge;
  logic cur_left, cur_right, row_load, row_dec, do_place, dir_clr, dir_inc;
  logic set_win, set_draw, do_toggle, do_restart;
  logic line_match;
  logic [LINE_LEN-1:0][1:0] line;
  int dr, dc;

  assign left_edge  = io.btn_left  & ~left_q;
  assign right_edge = io.btn_right & ~right_q;
  assign drop_edge  = io.btn_drop  & ~drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SELECT;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    cur_left   = 1'b0;
    cur_right  = 1'b0;
    row_load   = 1'b0;
    row_dec    = 1'b0;
    do_place   = 1'b0;
    dir_clr    = 1'b0;
    dir_inc    = 1'b0;
    set_win    = 1'b0;
    set_draw   = 1'b0;
    do_toggle  = 1'b0;
    do_restart = 1'b0;
    case (state_q)
      ST_SELECT: begin
        if (drop_edge) begin
          row_load  = 1'b1;
          state_nxt = ST_SCAN;
        end else if (left_edge && !right_edge) begin
          cur_left = 1'b1;
        end else if (right_edge && !left_edge) begin
          cur_right = 1'b1;
        end
      end
      ST_SCAN: begin
        if (board_q[row_q][cursor_q] == CELL_EMPTY) state_nxt = ST_PLACE;
        else if (row_q == 3'd0)                     state_nxt = ST_SELECT;
        else                                        row_dec   = 1'b1;
      end
      ST_PLACE: begin
        do_place  = 1'b1;
        dir_clr   = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (line_match) begin
          set_win   = 1'b1;
          state_nxt = ST_TERM;
        end else if (dir_q == DIR_UR) begin
          state_nxt = ST_NEXT;
        end else begin
          dir_inc = 1'b1;
        end
      end
      ST_NEXT: begin
        if (moves_q == MAX_MOVES) begin
          set_draw  = 1'b1;
          state_nxt = ST_TERM;
        end else begin
          do_toggle = 1'b1;
          state_nxt = ST_SELECT;
        end
      end
      ST_TERM: begin
        if (drop_edge) begin
          do_restart = 1'b1;
          state_nxt  = ST_SELECT;
        end
      end
      default: state_nxt = ST_SELECT;
    endcase
  end

  // 7-cell line centred on the placed cell; cells off the board read as empty.
  always_comb begin
    dr = 0;
    dc = 1;
    case (dir_q)
      DIR_H:   begin dr = 0;  dc = 1; end
      DIR_V:   begin dr = 1;  dc = 0; end
      DIR_DR:  begin dr = 1;  dc = 1; end
      default: begin dr = -1; dc = 1; end
    endcase
    line = '0;
    for (int k = 0; k < LINE_LEN; k++) begin
      int lr, lc;
      lr = int'(row_q) + (k - HALF) * dr;
      lc = int'(cursor_q) + (k - HALF) * dc;
      if (lr >= 0 && lr < ROWS && lc >= 0 && lc < COLS)
        line[k] = board_q[lr[2:0]][lc[2:0]];
    end
  end

  connect4_line_check #(
    .LINE_LEN (LINE_LEN),
    .WIN_LEN  (WIN_LEN)
  ) u_line_check (
    .line   (line),
    .player (player_q),
    .match  (line_match)
  );

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign grid_nxt[SEL_BASE-2*c -: 2] = (cursor_q == 3'(c)) ? player_q : CELL_EMPTY;
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign grid_nxt[cell_idx(r, c) -: 2] = board_q[r][c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q  <= '{default: CELL_EMPTY};
      cursor_q <= 3'd0;
      row_q    <= 3'd0;
      dir_q    <= DIR_H;
      player_q <= CELL_P1;
      moves_q  <= 6'd0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      drop_q   <= 1'b0;
      winner_q <= 2'b00;
      term_q   <= 1'b0;
      busy_q   <= 1'b0;
      grid_q   <= {{(GRID_W-2){1'b0}}, CELL_P1} << (SEL_BASE - 1);
    end else begin
      left_q  <= io.btn_left;
      right_q <= io.btn_right;
      drop_q  <= io.btn_drop;

      if (cur_left) begin
`ifdef CONNECT4_CURSOR_WRAP_EN
        cursor_q <= (cursor_q == 3'd0) ? 3'(COLS - 1) : cursor_q - 3'd1;
`else
        if (cursor_q != 3'd0) cursor_q <= cursor_q - 3'd1;
`endif
      end else if (cur_right) begin
`ifdef CONNECT4_CURSOR_WRAP_EN
        cursor_q <= (cursor_q == 3'(COLS - 1)) ? 3'd0 : cursor_q + 3'd1;
`else
        if (cursor_q != 3'(COLS - 1)) cursor_q <= cursor_q + 3'd1;
`endif
      end

      if (row_load)     row_q <= 3'(ROWS - 1);
      else if (row_dec) row_q <= row_q - 3'd1;

      if (do_place) begin
        board_q[row_q][cursor_q] <= player_q;
        moves_q                  <= moves_q + 6'd1;
      end

      if (dir_clr)      dir_q <= DIR_H;
      else if (dir_inc) dir_q <= dir_t'(dir_q + 2'd1);

      if (set_win) begin
        winner_q <= player_q;
        term_q   <= 1'b1;
      end
      if (set_draw) begin
        winner_q <= 2'b00;
        term_q   <= 1'b1;
      end
      if (do_toggle) player_q <= (player_q == CELL_P1) ? CELL_P2 : CELL_P1;

      if (do_restart) begin
        board_q  <= '{default: CELL_EMPTY};
        winner_q <= 2'b00;
        term_q   <= 1'b0;
        moves_q  <= 6'd0;
        player_q <= CELL_P1;
        cursor_q <= 3'd0;
      end

      busy_q <= (state_nxt != ST_SELECT) && (state_nxt != ST_TERM);
      grid_q <= grid_nxt;
    end
  end

  assign io.grid   = grid_q;
  assign io.winner = winner_q;
  assign io.term   = term_q;
  assign io.busy   = busy_q;

endmodule

// File: tb/tb_connect4_game.sv
// Directed bench for connect4_game: cursor, gravity, wins, full column, draw, restart and mid-scan reset.
module tb_connect4_game;
  import connect4_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  connect4_if io();

  connect4_game dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [97:0] reset_grid = 98'b1 << 96;

  // bench-side board model: mb[row][col], cursor, player to move
  logic [1:0] mb [6][7];
  int         mcur;
  logic [1:0] mpl;

  function automatic logic [97:0] model_grid();
    logic [97:0] g;
    g = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        g = g | ({96'b0, mb[r][c]} << (82 - 14 * r - 2 * c));
    g = g | ({96'b0, mpl} << (96 - 2 * mcur));
    return g;
  endfunction

  function automatic logic [1:0] sel_code(input int col);
    logic [97:0] t;
    t = io.grid >> (96 - 2 * col);
    return t[1:0];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        mb[r][c] = 2'b00;
    mcur = 0;
    mpl  = 2'b01;
  endtask

  task automatic model_place(input int col, input bit toggle);
    int r;
    r = 5;
    while (r >= 0 && mb[r][col] != 2'b00) r--;
    if (r >= 0) mb[r][col] = mpl;
    if (toggle) mpl = (mpl == 2'b01) ? 2'b10 : 2'b01;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    io.btn_left  = 1'b0;
    io.btn_right = 1'b0;
    io.btn_drop  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
  endtask

  // m = {drop, right, left}
  task automatic pulse(input logic [2:0] m);
    @(negedge clk);
    io.btn_left  = m[0];
    io.btn_right = m[1];
    io.btn_drop  = m[2];
    @(negedge clk);
    io.btn_left  = 1'b0;
    io.btn_right = 1'b0;
    io.btn_drop  = 1'b0;
  endtask

  task automatic press(input logic [2:0] m);
    pulse(m);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int lat);
    lat = 1;
    while (io.busy === 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic move_to(input int col);
    while (mcur < col) begin press(3'b010); mcur++; end
    while (mcur > col) begin press(3'b001); mcur--; end
  endtask

  task automatic drop(input int col, output int lat);
    move_to(col);
    pulse(3'b100);
    wait_idle(lat);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (io.grid !== reset_grid) $display("FAIL reset_grid: got %h want %h", io.grid, reset_grid); else n_pass++;
    n_checks++; if (io.winner !== 2'b00) $display("FAIL reset_winner: got %b want 00", io.winner); else n_pass++;
    n_checks++; if (io.term !== 1'b0) $display("FAIL reset_term: got %b want 0", io.term); else n_pass++;
    n_checks++; if (io.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", io.busy); else n_pass++;
  endtask

  task automatic test_first_drop();
    int lat;
    do_reset();
    drop(3, lat);
    model_place(3, 1);
    n_checks++; if (io.grid[91:90] !== 2'b10) $display("FAIL first_sel_col3: got %b want 10", io.grid[91:90]); else n_pass++;
    n_checks++; if (io.grid[97:96] !== 2'b00) $display("FAIL first_sel_col0: got %b want 00", io.grid[97:96]); else n_pass++;
    n_checks++; if (io.grid[7:6] !== 2'b01) $display("FAIL first_cell_5_3: got %b want 01", io.grid[7:6]); else n_pass++;
    n_checks++; if (io.grid !== model_grid()) $display("FAIL first_grid: got %h want %h", io.grid, model_grid()); else n_pass++;
    n_checks++; if (lat - 1 !== 7) $display("FAIL first_latency: got %0d want 7", lat - 1); else n_pass++;
    n_checks++; if (io.term !== 1'b0) $display("FAIL first_term: got %b want 0", io.term); else n_pass++;
  endtask

  task automatic test_horizontal_win();
    int lat;
    int seq [6] = '{0, 6, 1, 6, 2, 6};
    do_reset();
    foreach (seq[i]) begin
      drop(seq[i], lat);
      model_place(seq[i], 1);
    end
    n_checks++; if (io.term !== 1'b0) $display("FAIL hwin_pre_term: got %b want 0", io.term); else n_pass++;
    drop(3, lat);
    model_place(3, 0);
    n_checks++; if (io.winner !== 2'b01) $display("FAIL hwin_winner: got %b want 01", io.winner); else n_pass++;
    n_checks++; if (io.term !== 1'b1) $display("FAIL hwin_term: got %b want 1", io.term); else n_pass++;
    n_checks++; if (io.busy !== 1'b0) $display("FAIL hwin_busy: got %b want 0", io.busy); else n_pass++;
    n_checks++; if (lat - 1 > 12) $display("FAIL hwin_latency: got %0d want <=12", lat - 1); else n_pass++;
    n_checks++; if (io.grid !== model_grid()) $display("FAIL hwin_grid: got %h want %h", io.grid, model_grid()); else n_pass++;
    press(3'b001);
    n_checks++; if (io.grid !== model_grid()) $display("FAIL hwin_frozen: got %h want %h", io.grid, model_grid()); else n_pass++;
  endtask

  task automatic test_full_column();
    int lat;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drop(0, lat);
      model_place(0, 1);
    end
    n_checks++; if (io.grid !== model_grid()) $display("FAIL full_col_grid: got %h want %h", io.grid, model_grid()); else n_pass++;
    drop(0, lat);
    n_checks++; if (io.grid !== model_grid()) $display("FAIL full_col_unchanged: got %h want %h", io.grid, model_grid()); else n_pass++;
    n_checks++; if (sel_code(0) !== 2'b01) $display("FAIL full_col_player: got %b want 01", sel_code(0)); else n_pass++;
    n_checks++; if (lat - 1 > 7) $display("FAIL full_col_latency: got %0d want <=7", lat - 1); else n_pass++;
    n_checks++; if (io.term !== 1'b0) $display("FAIL full_col_term: got %b want 0", io.term); else n_pass++;
  endtask

  task automatic test_cursor_edges();
    int lat;
    do_reset();
    press(3'b001);
`ifdef CONNECT4_CURSOR_WRAP_EN
    mcur = 6;
`else
    mcur = 0;
`endif
    n_checks++; if (io.grid !== model_grid()) $display("FAIL cursor_left_edge: got %h want %h", io.grid, model_grid()); else n_pass++;
    move_to(6);
    press(3'b010);
`ifdef CONNECT4_CURSOR_WRAP_EN
    mcur = 0;
`else
    mcur = 6;
`endif
    n_checks++; if (io.grid !== model_grid()) $display("FAIL cursor_right_edge: got %h want %h", io.grid, model_grid()); else n_pass++;
    move_to(2);
    press(3'b011);
    n_checks++; if (io.grid !== model_grid()) $display("FAIL cursor_both: got %h want %h", io.grid, model_grid()); else n_pass++;
    pulse(3'b110);
    wait_idle(lat);
    model_place(2, 1);
    n_checks++; if (io.grid !== model_grid()) $display("FAIL drop_priority: got %h want %h", io.grid, model_grid()); else n_pass++;
    n_checks++; if (sel_code(2) !== 2'b10) $display("FAIL drop_priority_sel: got %b want 10", sel_code(2)); else n_pass++;
  endtask

  task automatic test_diag_win();
    int lat;
    int seq [11] = '{2, 1, 3, 2, 3, 6, 4, 3, 4, 6, 4};
    do_reset();
    foreach (seq[i]) begin
      drop(seq[i], lat);
      model_place(seq[i], 1);
    end
    n_checks++; if (io.term !== 1'b0) $display("FAIL diag_pre_term: got %b want 0", io.term); else n_pass++;
    drop(4, lat);
    model_place(4, 0);
    n_checks++; if (io.winner !== 2'b10) $display("FAIL diag_winner: got %b want 10", io.winner); else n_pass++;
    n_checks++; if (io.term !== 1'b1) $display("FAIL diag_term: got %b want 1", io.term); else n_pass++;
    n_checks++; if (io.grid !== model_grid()) $display("FAIL diag_grid: got %h want %h", io.grid, model_grid()); else n_pass++;
    press(3'b010);
    n_checks++; if (io.grid !== model_grid()) $display("FAIL diag_frozen: got %h want %h", io.grid, model_grid()); else n_pass++;
    press(3'b100);
    n_checks++; if (io.grid !== reset_grid) $display("FAIL restart_grid: got %h want %h", io.grid, reset_grid); else n_pass++;
    n_checks++; if (io.term !== 1'b0) $display("FAIL restart_term: got %b want 0", io.term); else n_pass++;
    n_checks++; if (io.winner !== 2'b00) $display("FAIL restart_winner: got %b want 00", io.winner); else n_pass++;
  endtask

  task automatic test_draw();
    int lat;
    int max_lat;
    int blk [6] = '{6, 4, 4, 5, 5, 6};
    int order [42];
    int n;
    logic [97:0] exp_g;
    do_reset();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      order[n] = (i % 2 == 0) ? 2 : 0; n++;
      order[n] = (i % 2 == 0) ? 0 : 2; n++;
    end
    for (int i = 0; i < 6; i++) begin
      order[n] = (i % 2 == 0) ? 3 : 1; n++;
      order[n] = (i % 2 == 0) ? 1 : 3; n++;
    end
    for (int b = 0; b < 3; b++)
      foreach (blk[j]) begin order[n] = blk[j]; n++; end
    max_lat = 0;
    foreach (order[i]) begin
      drop(order[i], lat);
      if (lat > max_lat) max_lat = lat;
    end
    // final board: P1 where ((col>>1)+row) is even, P2 otherwise; P2 made the last move in col 6
    exp_g = 98'b10 << 84;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        exp_g = exp_g | ((((c >> 1) + r) % 2 == 0 ? 98'b01 : 98'b10) << (82 - 14 * r - 2 * c));
    n_checks++; if (io.term !== 1'b1) $display("FAIL draw_term: got %b want 1", io.term); else n_pass++;
    n_checks++; if (io.winner !== 2'b00) $display("FAIL draw_winner: got %b want 00", io.winner); else n_pass++;
    n_checks++; if (io.busy !== 1'b0) $display("FAIL draw_busy: got %b want 0", io.busy); else n_pass++;
    n_checks++; if (io.grid !== exp_g) $display("FAIL draw_grid: got %h want %h", io.grid, exp_g); else n_pass++;
    n_checks++; if (max_lat - 1 > 12) $display("FAIL draw_max_latency: got %0d want <=12", max_lat - 1); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drop(0, lat);
      model_place(0, 1);
    end
    @(negedge clk);
    io.btn_drop = 1'b1;
    @(negedge clk);
    io.btn_drop = 1'b0;
    n_checks++; if (io.busy !== 1'b1) $display("FAIL midscan_busy_before: got %b want 1", io.busy); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (io.grid !== reset_grid) $display("FAIL midscan_grid: got %h want %h", io.grid, reset_grid); else n_pass++;
    n_checks++; if (io.busy !== 1'b0) $display("FAIL midscan_busy: got %b want 0", io.busy); else n_pass++;
    n_checks++; if (io.term !== 1'b0) $display("FAIL midscan_term: got %b want 0", io.term); else n_pass++;
    n_checks++; if (io.winner !== 2'b00) $display("FAIL midscan_winner: got %b want 00", io.winner); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++; if (io.grid !== reset_grid) $display("FAIL midscan_no_partial: got %h want %h", io.grid, reset_grid); else n_pass++;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io.btn_left  = 1'b0;
    io.btn_right = 1'b0;
    io.btn_drop  = 1'b0;
    model_clear();
    test_reset();
    test_first_drop();
    test_horizontal_win();
    test_full_column();
    test_cursor_edges();
    test_diag_win();
    test_draw();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
